// File: rtl/cv32e40p_hwlp_pkg.sv
// Shared types for the hardware-loop controller: FSM state encoding and default loop count.
package cv32e40p_hwlp_pkg;

  localparam int HWLP_N_REGS_DEFAULT = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } hwlp_ctrl_state_e;

endpackage

// File: rtl/cv32e40p_hwloop_match.sv
// Combinational end-address compare across all hardware loops with lowest-index priority.
// Reports whether a loop ends at the ID PC, which loop wins, and whether it must jump back.
module cv32e40p_hwloop_match #(
  parameter int N_REGS     = 2,
  parameter int N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic [31:0]              pc_id_i,
  input  logic                     pc_id_valid_i,
  input  logic                     flush_i,
  input  logic [N_REGS-1:0][31:0]  hwlp_end_addr_i,
  input  logic [N_REGS-1:0][31:0]  hwlp_counter_i,
  output logic                     match,
  output logic [N_REG_BITS-1:0]    idx,
  output logic                     take_jump
);

  // Scan from the outermost loop down so the innermost hit is the last one written.
  always_comb begin
    match     = 1'b0;
    idx       = '0;
    take_jump = 1'b0;
    for (int i = N_REGS - 1; i >= 0; i--) begin
      if (pc_id_valid_i && !flush_i &&
          (pc_id_i == hwlp_end_addr_i[i]) && (hwlp_counter_i[i] != 32'd0)) begin
        match     = 1'b1;
        idx       = N_REG_BITS'(i);
        take_jump = hwlp_counter_i[i] > 32'd1;
      end
    end
  end

endmodule

// File: rtl/cv32e40p_hwloop_ctrl.sv
// Hardware-loop controller: issues one decrement and at most one jump per loop-end instruction,
// holding each request until consumed. Optional jump counter: CV32E40P_HWLP_PERF_CNT_EN.
//
// Handshakes: the decrement request is consumed in a cycle where id_valid_i is high; the jump
// request is consumed in a cycle where hwlp_jump_o and hwlp_jump_ack_i are both high. Each
// request stays asserted with stable payload until consumed or flush_i drops it.
module cv32e40p_hwloop_ctrl
  import cv32e40p_hwlp_pkg::*;
#(
  parameter int N_REGS     = HWLP_N_REGS_DEFAULT,
  parameter int N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              pc_id_i,
  input  logic                     pc_id_valid_i,
  input  logic                     id_valid_i,
  input  logic                     flush_i,
  input  logic [N_REGS-1:0][31:0]  hwlp_start_addr_i,
  input  logic [N_REGS-1:0][31:0]  hwlp_end_addr_i,
  input  logic [N_REGS-1:0][31:0]  hwlp_counter_i,
  output logic [N_REGS-1:0]        hwlp_dec_cnt_o,
  output logic                     hwlp_jump_o,
  output logic [31:0]              hwlp_targ_addr_o,
  input  logic                     hwlp_jump_ack_i,
`ifdef CV32E40P_HWLP_PERF_CNT_EN
  input  logic                     hwlp_jump_cnt_clr_i,
  output logic [31:0]              hwlp_jump_cnt_o,
`endif
  output hwlp_ctrl_state_e         hwlp_state_o
);

  hwlp_ctrl_state_e        state_q, state_d;
  logic                    dec_pend_q, dec_pend_d;
  logic                    jmp_pend_q, jmp_pend_d;
  logic [N_REG_BITS-1:0]   idx_q, idx_d;
  logic [31:0]             targ_q, targ_d;

  logic                    match;
  logic [N_REG_BITS-1:0]   idx;
  logic                    take_jump;

  cv32e40p_hwloop_match #(
    .N_REGS     (N_REGS),
    .N_REG_BITS (N_REG_BITS)
  ) u_match (
    .pc_id_i         (pc_id_i),
    .pc_id_valid_i   (pc_id_valid_i),
    .flush_i         (flush_i),
    .hwlp_end_addr_i (hwlp_end_addr_i),
    .hwlp_counter_i  (hwlp_counter_i),
    .match           (match),
    .idx             (idx),
    .take_jump       (take_jump)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dec_pend_q <= 1'b0;
      jmp_pend_q <= 1'b0;
      idx_q      <= '0;
      targ_q     <= '0;
    end else begin
      state_q    <= state_d;
      dec_pend_q <= dec_pend_d;
      jmp_pend_q <= jmp_pend_d;
      idx_q      <= idx_d;
      targ_q     <= targ_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    dec_pend_d       = dec_pend_q;
    jmp_pend_d       = jmp_pend_q;
    idx_d            = idx_q;
    targ_d           = targ_q;
    hwlp_dec_cnt_o   = '0;
    hwlp_jump_o      = 1'b0;
    hwlp_targ_addr_o = '0;

    case (state_q)
      IDLE: begin
        if (match) begin
          hwlp_dec_cnt_o[idx] = 1'b1;
          hwlp_jump_o         = take_jump;
          hwlp_targ_addr_o    = hwlp_start_addr_i[idx];
          // Anything not consumed in the match cycle is parked until the pipeline takes it.
          if (!(id_valid_i && (!take_jump || hwlp_jump_ack_i))) begin
            state_d    = BUSY;
            idx_d      = idx;
            targ_d     = hwlp_start_addr_i[idx];
            dec_pend_d = !id_valid_i;
            jmp_pend_d = take_jump && !hwlp_jump_ack_i;
          end
        end
      end
      BUSY: begin
        // A killed instruction must never reach the regfile as a decrement.
        if (dec_pend_q && !flush_i) hwlp_dec_cnt_o[idx_q] = 1'b1;
        hwlp_jump_o      = jmp_pend_q;
        hwlp_targ_addr_o = targ_q;
        if (id_valid_i)      dec_pend_d = 1'b0;
        if (hwlp_jump_ack_i) jmp_pend_d = 1'b0;
        if (!dec_pend_d && !jmp_pend_d) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush_i) begin
      state_d    = IDLE;
      dec_pend_d = 1'b0;
      jmp_pend_d = 1'b0;
    end
  end

  assign hwlp_state_o = state_q;

`ifdef CV32E40P_HWLP_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hwlp_jump_cnt_o <= '0;
    end else if (hwlp_jump_cnt_clr_i) begin
      hwlp_jump_cnt_o <= '0;
    end else if (hwlp_jump_o && hwlp_jump_ack_i) begin
      hwlp_jump_cnt_o <= hwlp_jump_cnt_o + 32'd1;
    end
  end
`else
  // Jump counter not present in this build.
`endif

  a_dec_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $countones(hwlp_dec_cnt_o) <= 1);

endmodule
